// File: rtl/regfile_viewer_pkg.sv
// Shared types and constants for the register-file viewer.
package regfile_viewer_pkg;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 8;

  function automatic logic [15:0] zext16(input logic [15:0] v);
    return v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-counter debouncer and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned     CntW   = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where the input agrees with the accepted level restarts the count.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/regfile_viewer.sv
// Debounced register bank with two read ports, clear sweep, auto-scan and hex-digit packing.
module regfile_viewer
  import regfile_viewer_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned W          = 8,
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned SCAN_TICKS = 100_000_000,
  parameter int unsigned ZERO_R0    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_we,
  input  logic         btn_clr,
  input  logic         mode_scan,
  input  logic [N-1:0] addr_wr,
  input  logic [N-1:0] addr_rs1,
  input  logic [N-1:0] addr_rs2,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] rs1,
  output logic [W-1:0] rs2,
  output logic [N-1:0] disp_addr,
  output logic [31:0]  digits,
  output logic         busy,
  output logic [7:0]   wr_count
);

  localparam int unsigned      DEPTH   = 1 << N;
  localparam logic [N-1:0]     LastIdx = N'(DEPTH - 1);
  localparam int unsigned      TickW   = $clog2(SCAN_TICKS + 1);
  localparam logic [TickW-1:0] TickMax = TickW'(SCAN_TICKS - 1);

  logic we_p, clr_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_we (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_we),
    .pulse_o(we_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_clr),
    .pulse_o(clr_p)
  );

  logic [1:0]       mode_sync_q, mode_sync_d;
  logic             mode_scan_s;
  state_e           state_q, state_d;
  logic [N-1:0]     clr_idx_q, clr_idx_d;
  logic [7:0]       wr_count_q, wr_count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [W-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, scan_q, scan_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [N-1:0]     disp_addr_q, disp_addr_d;
  logic [31:0]      digits_q, digits_d;
  logic             wr_en;
  logic [N-1:0]     wr_addr;
  logic [W-1:0]     wr_data;

  assign mode_sync_d = {mode_sync_q[0], mode_scan};
  assign mode_scan_s = mode_sync_q[1];

  // Control FSM: a clear pulse takes priority over a same-cycle write pulse.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    wr_addr    = addr_wr;
    wr_data    = data_in;
    unique case (state_q)
      StIdle: begin
        if (clr_p) begin
          state_d    = StClear;
          clr_idx_d  = '0;
          wr_count_d = '0;
        end else if (we_p && !(ZERO_R0 != 0 && addr_wr == '0)) begin
          wr_en = 1'b1;
          if (wr_count_q != 8'hFF) begin
            wr_count_d = wr_count_q + 8'd1;
          end
        end
      end
      StClear: begin
        wr_en     = 1'b1;
        wr_addr   = clr_idx_q;
        wr_data   = '0;
        clr_idx_d = clr_idx_q + N'(1);
        if (clr_idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // mem_d carries this cycle's write, so reads of mem_d give write-to-read bypass.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    rs1_d  = (ZERO_R0 != 0 && addr_rs1 == '0) ? '0 : mem_d[addr_rs1];
    rs2_d  = (ZERO_R0 != 0 && addr_rs2 == '0) ? '0 : mem_d[addr_rs2];
    scan_d = (ZERO_R0 != 0 && disp_addr_q == '0) ? '0 : mem_d[disp_addr_q];
  end

  always_comb begin
    tick_d      = '0;
    disp_addr_d = '0;
    if (mode_scan_s) begin
      disp_addr_d = disp_addr_q;
      if (tick_q == TickMax) begin
        disp_addr_d = disp_addr_q + N'(1);
      end else begin
        tick_d = tick_q + TickW'(1);
      end
    end
  end

  always_comb begin
    if (mode_scan_s) begin
      digits_d = {DIGIT_W'(disp_addr_q), 12'h000, zext16(16'(scan_q))};
    end else begin
      digits_d = {zext16(16'(rs2_q)), zext16(16'(rs1_q))};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= '0;
      state_q     <= StIdle;
      clr_idx_q   <= '0;
      wr_count_q  <= '0;
      mem_q       <= '{default: '0};
      rs1_q       <= '0;
      rs2_q       <= '0;
      scan_q      <= '0;
      tick_q      <= '0;
      disp_addr_q <= '0;
      digits_q    <= '0;
    end else begin
      mode_sync_q <= mode_sync_d;
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      wr_count_q  <= wr_count_d;
      mem_q       <= mem_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      scan_q      <= scan_d;
      tick_q      <= tick_d;
      disp_addr_q <= disp_addr_d;
      digits_q    <= digits_d;
    end
  end

  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign disp_addr = disp_addr_q;
  assign digits    = digits_q;
  assign busy      = (state_q == StClear);
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_viewer.sv
// Directed bench for regfile_viewer; a second instance has register 0 hardwired to zero.
module tb_regfile_viewer;

  logic        clk = 1'b0;
  logic        rst_n, btn_we, btn_clr, mode_scan;
  logic [2:0]  addr_wr, addr_rs1, addr_rs2;
  logic [7:0]  data_in;
  logic [7:0]  rs1_a, rs2_a, wrc_a, rs1_b, rs2_b, wrc_b;
  logic [2:0]  disp_a, disp_b;
  logic [31:0] dig_a, dig_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_viewer #(
    .N(3), .W(8), .DB_CYCLES(4), .SCAN_TICKS(8), .ZERO_R0(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_we(btn_we), .btn_clr(btn_clr), .mode_scan(mode_scan),
    .addr_wr(addr_wr), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .data_in(data_in),
    .rs1(rs1_a), .rs2(rs2_a), .disp_addr(disp_a), .digits(dig_a), .busy(busy_a),
    .wr_count(wrc_a)
  );

  regfile_viewer #(
    .N(3), .W(8), .DB_CYCLES(4), .SCAN_TICKS(8), .ZERO_R0(1)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .btn_we(btn_we), .btn_clr(btn_clr), .mode_scan(mode_scan),
    .addr_wr(addr_wr), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .data_in(data_in),
    .rs1(rs1_b), .rs2(rs2_b), .disp_addr(disp_b), .digits(dig_b), .busy(busy_b),
    .wr_count(wrc_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_we(input logic [2:0] a, input logic [7:0] d);
    addr_wr = a;
    data_in = d;
    btn_we  = 1'b1;
    tick(20);
    btn_we  = 1'b0;
    tick(10);
  endtask

  initial begin
    int n;
    logic [7:0] prev;
    rst_n = 1'b0; btn_we = 1'b0; btn_clr = 1'b0; mode_scan = 1'b0;
    addr_wr = '0; addr_rs1 = '0; addr_rs2 = '0; data_in = '0;
    tick(3);
    check("rst_rs1", rs1_a, 0);
    check("rst_rs2", rs2_a, 0);
    check("rst_disp", disp_a, 0);
    check("rst_digits", dig_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_wrcount", wrc_a, 0);
    rst_n = 1'b1;
    tick(3);

    // Held button gives exactly one write
    addr_rs1 = 3'd3;
    press_we(3'd3, 8'hA5);
    check("wr_rs1", rs1_a, 32'hA5);
    check("wr_digits", dig_a, 32'h0000_00A5);
    check("wr_count1", wrc_a, 1);
    press_we(3'd3, 8'hA5);
    check("wr_count2", wrc_a, 2);

    // Bounce shorter than DB_CYCLES is rejected
    addr_wr = 3'd4; data_in = 8'h77;
    for (int i = 0; i < 10; i++) begin
      btn_we = 1'b1; tick(2);
      btn_we = 1'b0; tick(2);
    end
    tick(10);
    check("bounce_wrcount", wrc_a, 2);

    // Bypass: rs2 shows new data on the same edge that commits the write
    addr_wr = 3'd5; addr_rs2 = 3'd5; data_in = 8'h5A;
    btn_we = 1'b1;
    n = 0;
    while (wrc_a == 8'd2 && n < 40) begin
      tick(1);
      n++;
    end
    check("bypass_seen", (n < 40) ? 1 : 0, 1);
    check("bypass_rs2", rs2_a, 32'h5A);
    tick(20);
    btn_we = 1'b0;
    tick(10);

    // Clear sweep with a write pressed mid-sweep
    for (int i = 0; i < 8; i++) press_we(3'(i), 8'(8'h11 * (i + 1)));
    check("pre_clr_wrcount", wrc_a, 11);
    addr_wr = 3'd7; data_in = 8'hEE;
    btn_clr = 1'b1;
    tick(2);
    btn_we = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy_a) n++;
    end
    check("clr_busy_cycles", n, 8);
    btn_clr = 1'b0; btn_we = 1'b0;
    tick(10);
    check("clr_wrcount", wrc_a, 0);
    for (int i = 0; i < 8; i++) begin
      addr_rs1 = 3'(i); addr_rs2 = 3'(7 - i);
      tick(1);
      check($sformatf("clr_read%0d", i), {rs2_a, rs1_a}, 0);
    end

    // Reset during sweep clears busy immediately
    btn_clr = 1'b1;
    n = 0;
    while (!busy_a && n < 30) begin
      tick(1);
      n++;
    end
    check("midsweep_busy", busy_a, 1);
    btn_clr = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midsweep_rst_busy", busy_a, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Scan mode
    for (int i = 1; i < 8; i++) press_we(3'(i), 8'(8'h10 * i));
    addr_rs1 = 3'd2; addr_rs2 = 3'd6;
    tick(2);
    mode_scan = 1'b1;
    n = 0;
    while (disp_a != 3'd1 && n < 40) begin tick(1); n++; end
    check("scan_reach1", disp_a, 1);
    n = 0;
    while (disp_a == 3'd1 && n < 40) begin tick(1); n++; end
    check("scan_dwell", n, 8);
    check("scan_step", disp_a, 2);
    n = 0;
    while (disp_a != 3'd3 && n < 40) begin tick(1); n++; end
    tick(2);
    check("scan_digits3", dig_a, 32'h3000_0030);
    n = 0;
    while (disp_a != 3'd7 && n < 60) begin tick(1); n++; end
    check("scan_reach7", disp_a, 7);
    n = 0;
    while (disp_a == 3'd7 && n < 40) begin tick(1); n++; end
    check("scan_wrap", disp_a, 0);
    mode_scan = 1'b0;
    tick(3);
    check("manual_digits", dig_a, 32'h0060_0020);
    check("manual_disp", disp_a, 0);

    // Hardwired register 0
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    addr_rs1 = 3'd0;
    press_we(3'd0, 8'hFF);
    check("z0_plain_rs1", rs1_a, 32'hFF);
    check("z0_rs1", rs1_b, 0);
    check("z0_wrcount", wrc_b, 0);
    addr_rs1 = 3'd1;
    prev = wrc_b;
    press_we(3'd1, 8'h42);
    check("z1_rs1", rs1_b, 32'h42);
    check("z1_wrcount", wrc_b, 32'(prev) + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
